uart_rx_oversampled: RTL

Standalone UART receiver. It accepts the serial frames produced by the team's transmitter unit: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It recovers each byte with 16x oversampling and majority-vote sampling, then reports the byte together with per-frame error flags. It sits on the receive end of a link whose far side is a transmitter unit on another device, or on the same die for loopback.

---
 rtl/uart_rx_oversampled_if.sv | 37 +++
 rtl/uart_rx_oversampled.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Serial line, frame configuration and result bundle of the
//               oversampling UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic       data_tx;
    logic [7:0] data_out;
    logic [2:0] error_flag;
    logic       active_flag;
    logic       done_flag;

    modport master (
        output parity_type,
        output baud_rate,
        output data_tx,
        input  data_out,
        input  error_flag,
        input  active_flag,
        input  done_flag
    );

    modport slave (
        input  parity_type,
        input  baud_rate,
        input  data_tx,
        output data_out,
        output error_flag,
        output active_flag,
        output done_flag
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 16x oversampling UART receiver, 8 data bits, optional parity,
//               one stop bit, majority vote at ticks 7/8/9 of every bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    uart_rx_oversampled_if.slave  rx
);

    localparam int unsigned c_DIV_2400  = CLK_FREQ / (2400  * OVERSAMPLE);
    localparam int unsigned c_DIV_4800  = CLK_FREQ / (4800  * OVERSAMPLE);
    localparam int unsigned c_DIV_9600  = CLK_FREQ / (9600  * OVERSAMPLE);
    localparam int unsigned c_DIV_19200 = CLK_FREQ / (19200 * OVERSAMPLE);
    localparam int          c_DIV_W     = ($clog2(c_DIV_2400) < 1) ? 1 : $clog2(c_DIV_2400);

    localparam logic [c_DIV_W-1:0] c_LAST_2400  = c_DIV_W'(c_DIV_2400  - 1);
    localparam logic [c_DIV_W-1:0] c_LAST_4800  = c_DIV_W'(c_DIV_4800  - 1);
    localparam logic [c_DIV_W-1:0] c_LAST_9600  = c_DIV_W'(c_DIV_9600  - 1);
    localparam logic [c_DIV_W-1:0] c_LAST_19200 = c_DIV_W'(c_DIV_19200 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_sync_valid;
    logic                 r_line_prev;
    logic                 w_fall;

    logic [1:0]           r_baud_sel;
    logic [1:0]           r_par_sel;
    logic                 w_par_en;
    logic [c_DIV_W-1:0]   w_div_last;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic                 w_tick;
    logic [3:0]           r_os_cnt;
    logic [1:0]           r_samp;
    logic                 w_vote_now;
    logic                 w_vote;

    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_par_err;

    logic                 w_start_det;
    logic                 w_start_err;
    logic                 w_shift_en;
    logic                 w_par_chk;
    logic                 w_frame_done;

    logic [7:0]           r_data_out;
    logic [2:0]           r_error;
    logic                 r_active;
    logic                 r_done;

    // r_line_prev only trusts the synchronizer once real line data has
    // propagated, so a line held low across reset release is not an edge.
    assign w_fall     = r_line_prev & ~r_sync2;
    assign w_par_en   = (r_par_sel == 2'b01) || (r_par_sel == 2'b10);
    assign w_tick     = (r_state != IDLE) && (r_div_cnt == w_div_last);
    assign w_vote_now = w_tick && (r_os_cnt == 4'd8);
    assign w_vote     = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_sync2) |
                        (r_samp[0] & r_sync2);

    always_comb begin
        w_div_last = c_LAST_9600;
        case (r_baud_sel)
            2'b00:   w_div_last = c_LAST_2400;
            2'b01:   w_div_last = c_LAST_4800;
            2'b10:   w_div_last = c_LAST_9600;
            default: w_div_last = c_LAST_19200;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_start_err  = 1'b0;
        w_shift_en   = 1'b0;
        w_par_chk    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_start_det  = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_vote_now) begin
                    if (w_vote) begin
                        w_start_err  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_vote_now) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = w_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_vote_now) begin
                    w_par_chk    = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_vote_now) begin
                    w_frame_done = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_valid <= 2'b00;
            r_line_prev  <= 1'b0;
            r_baud_sel   <= 2'b00;
            r_par_sel    <= 2'b00;
            r_div_cnt    <= '0;
            r_os_cnt     <= 4'd0;
            r_samp       <= 2'b11;
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_par_err    <= 1'b0;
            r_data_out   <= 8'h00;
            r_error      <= 3'b000;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sync1      <= rx.data_tx;
            r_sync2      <= r_sync1;
            r_sync_valid <= {r_sync_valid[0], 1'b1};
            r_line_prev  <= r_sync2 & r_sync_valid[1];
            r_done       <= w_frame_done;

            // Config is latched here so mid-frame changes wait for the next frame.
            if (w_start_det) begin
                r_baud_sel <= rx.baud_rate;
                r_par_sel  <= rx.parity_type;
                r_div_cnt  <= '0;
                r_os_cnt   <= 4'd0;
                r_bit_cnt  <= 3'd0;
                r_par_err  <= 1'b0;
                r_active   <= 1'b1;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= r_os_cnt + 4'd1;
                if (r_os_cnt == 4'd6) begin
                    r_samp[1] <= r_sync2;
                end
                if (r_os_cnt == 4'd7) begin
                    r_samp[0] <= r_sync2;
                end
            end else if (r_state != IDLE) begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end

            if (w_shift_en) begin
                r_shift   <= {w_vote, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_par_chk) begin
                r_par_err <= (^r_shift) ^ w_vote ^ (r_par_sel == 2'b01);
            end

            if (w_start_err) begin
                r_error  <= 3'b010;
                r_active <= 1'b0;
            end

            if (w_frame_done) begin
                r_data_out <= r_shift;
                r_error    <= {~w_vote, 1'b0, r_par_err & w_par_en};
                r_active   <= 1'b0;
            end
        end
    end

    assign rx.data_out    = r_data_out;
    assign rx.error_flag  = r_error;
    assign rx.active_flag = r_active;
    assign rx.done_flag   = r_done;

endmodule
`default_nettype wire
